// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Purpose  : Queues read/write commands and replays them as APB SETUP/ACCESS
//            transfers against a word-addressed memory, one response each.
// Revision : 1.0  initial release
// ============================================================================
module apb_cmd_master #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 256,
    parameter int TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pvalid
);

    localparam int                c_ptr_w     = $clog2(DEPTH);
    localparam int                c_cnt_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_ptr_w:0]  c_full      = (c_ptr_w + 1)'(DEPTH);
    localparam logic [31:0]       c_mem_words = 32'(MEM_WORDS);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [31:0]       c_all_ones  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ACCESS  = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

    logic [31:0]        r_fifo_addr  [DEPTH];
    logic [31:0]        r_fifo_wdata [DEPTH];
    logic               r_fifo_write [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_wait_cnt;

    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_head_addr;
    logic [31:0]        w_head_wdata;
    logic               w_head_write;

    assign cmd_ready    = (r_count != c_full);
    assign w_push       = cmd_valid && cmd_ready;
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_head_addr  = r_fifo_addr[r_rd_ptr];
    assign w_head_wdata = r_fifo_wdata[r_rd_ptr];
    assign w_head_write = r_fifo_write[r_rd_ptr];

    // Storage needs no reset: only entries below r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= cmd_addr;
            r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
            r_fifo_write[r_wr_ptr] <= cmd_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= c_all_ones;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    if (w_pop) begin
                        if (w_head_addr >= c_mem_words) begin
                            // Rejected locally; the bus never sees it.
                            rsp_valid <= 1'b1;
                            rsp_write <= w_head_write;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= c_all_ones;
                        end else begin
                            paddr   <= w_head_addr;
                            pwrite  <= w_head_write;
                            pwdata  <= w_head_wdata;
                            psel    <= 1'b1;
                            r_state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    if (pwrite) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= c_all_ones;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait_cnt <= '0;
                        r_state    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (pvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= prdata;
                        r_state   <= S_IDLE;
                    end else if (r_wait_cnt == c_tmo_last) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= c_all_ones;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
